// File: rtl/spi_master_flex_if.sv
// Command-side bundle between a transaction sequencer and spi_master_flex.
// The sequencer drives the request fields; the master returns status and received data.
interface spi_master_flex_if #(
    parameter int MAX_BITS = 64,
    parameter int DIV_W    = 16,
    parameter int CS_W     = 1,
    parameter int LEN_W    = $clog2(MAX_BITS + 1)
);
    logic                i_start;
    logic [MAX_BITS-1:0] i_tx_data;
    logic [LEN_W-1:0]    i_bit_len;
    logic [CS_W-1:0]     i_cs_sel;
    logic                i_cpol;
    logic                i_cpha;
    logic [DIV_W-1:0]    i_div;
    logic                o_busy;
    logic                o_done;
    logic [MAX_BITS-1:0] o_rx_data;

    modport master (
        output i_start, i_tx_data, i_bit_len, i_cs_sel, i_cpol, i_cpha, i_div,
        input  o_busy, o_done, o_rx_data
    );

    modport slave (
        input  i_start, i_tx_data, i_bit_len, i_cs_sel, i_cpol, i_cpha, i_div,
        output o_busy, o_done, o_rx_data
    );
endinterface

// File: rtl/spi_master_flex.sv
// Runtime-configurable MSB-first SPI master: per-transaction length, mode, SCK divider
// and chip select, with CS setup/hold/gap timing and right-aligned receive data.
module spi_master_flex #(
    parameter int MAX_BITS = 64,
    parameter int NUM_CS   = 2,
    parameter int DIV_W    = 16,
    parameter int LEN_W    = $clog2(MAX_BITS + 1),
    parameter int CS_W     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              i_sys_clk,
    input  logic              i_reset_n,
    spi_master_flex_if.slave  cmd,
    output logic [NUM_CS-1:0] o_cs_n,
    output logic              o_sck,
    output logic              o_mosi,
    input  logic              i_miso
);
    localparam int EDGE_W = LEN_W + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_XFER  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]          state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d, div_lat_q, div_lat_d;
    logic [EDGE_W-1:0]   edge_q, edge_d, last_edge_q, last_edge_d;
    logic                cpha_q, cpha_d;
    logic [MAX_BITS-1:0] tx_q, tx_d, rx_q, rx_d, rx_out_q, rx_out_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic                sck_q, sck_d, mosi_q, mosi_d;
    logic [NUM_CS-1:0]   cs_n_q, cs_n_d, cs_dec;

    logic                len_ok, div_wrap, is_last, sample_edge;
    logic [LEN_W-1:0]    align_sh;
    logic [MAX_BITS-1:0] tx_aligned;
    logic [DIV_W-1:0]    div_in;

    // An out-of-range index matches no line, so every chip select stays high.
    always_comb begin
        for (int i = 0; i < NUM_CS; i++) begin
            cs_dec[i] = (cmd.i_cs_sel != CS_W'(i));
        end
    end

    assign len_ok      = (cmd.i_bit_len != '0) && (cmd.i_bit_len <= LEN_W'(MAX_BITS));
    assign align_sh    = LEN_W'(MAX_BITS) - cmd.i_bit_len;
    assign tx_aligned  = cmd.i_tx_data << align_sh;
    assign div_in      = (cmd.i_div == '0) ? DIV_W'(1) : cmd.i_div;
    assign div_wrap    = (div_q == div_lat_q - DIV_W'(1));
    assign is_last     = (edge_q == last_edge_q);
    // Even edge_q is a leading edge; CPHA selects which edge samples.
    assign sample_edge = ~edge_q[0] ^ cpha_q;

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        div_lat_d   = div_lat_q;
        edge_d      = edge_q;
        last_edge_d = last_edge_q;
        cpha_d      = cpha_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        rx_out_d    = rx_out_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        cs_n_d      = cs_n_q;
        sck_d       = sck_q;
        mosi_d      = mosi_q;
        case (state_q)
            S_IDLE: begin
                if (cmd.i_start && len_ok) begin
                    state_d     = S_SETUP;
                    busy_d      = 1'b1;
                    div_d       = '0;
                    edge_d      = '0;
                    last_edge_d = {cmd.i_bit_len, 1'b0} - EDGE_W'(1);
                    div_lat_d   = div_in;
                    cpha_d      = cmd.i_cpha;
                    sck_d       = cmd.i_cpol;
                    cs_n_d      = cs_dec;
                    rx_d        = '0;
                    tx_d        = tx_aligned;
                    mosi_d      = 1'b0;
                    // CPHA=0 needs the first bit on the wire before the first SCK edge.
                    if (!cmd.i_cpha) begin
                        mosi_d = tx_aligned[MAX_BITS-1];
                        tx_d   = {tx_aligned[MAX_BITS-2:0], 1'b0};
                    end
                end
            end
            S_SETUP, S_XFER: begin
                if (div_wrap) begin
                    div_d = '0;
                    sck_d = ~sck_q;
                    if (sample_edge) begin
                        rx_d = {rx_q[MAX_BITS-2:0], i_miso};
                    end else if (!is_last) begin
                        mosi_d = tx_q[MAX_BITS-1];
                        tx_d   = {tx_q[MAX_BITS-2:0], 1'b0};
                    end
                    if (is_last) begin
                        state_d = S_HOLD;
                    end else begin
                        edge_d  = edge_q + EDGE_W'(1);
                        state_d = S_XFER;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_HOLD: begin
                mosi_d = 1'b0;
                if (div_wrap) begin
                    div_d   = '0;
                    cs_n_d  = '1;
                    state_d = S_GAP;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_GAP: begin
                if (div_wrap) begin
                    div_d    = '0;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    rx_out_d = rx_q;
                    state_d  = S_IDLE;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= S_IDLE;
            div_q    <= '0;
            edge_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rx_out_q <= '0;
            cs_n_q   <= '1;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            edge_q   <= edge_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rx_out_q <= rx_out_d;
            cs_n_q   <= cs_n_d;
            sck_q    <= sck_d;
            mosi_q   <= mosi_d;
        end
    end

    // Per-transaction configuration and shift data are always loaded at accept.
    always_ff @(posedge i_sys_clk) begin
        div_lat_q   <= div_lat_d;
        last_edge_q <= last_edge_d;
        cpha_q      <= cpha_d;
        tx_q        <= tx_d;
        rx_q        <= rx_d;
    end

    assign cmd.o_busy    = busy_q;
    assign cmd.o_done    = done_q;
    assign cmd.o_rx_data = rx_out_q;
    assign o_cs_n        = cs_n_q;
    assign o_sck         = sck_q;
    assign o_mosi        = mosi_q;
endmodule

// File: tb/tb_spi_master_flex.sv
// Scoreboard bench for spi_master_flex: expectations are queued at start and
// compared on each done pulse, alongside a bus-level slave model.
module tb_spi_master_flex;
    logic       clk;
    logic       rst_n;
    logic [1:0] cs_n;
    logic       sck;
    logic       mosi;
    logic       miso;
    logic       loopback;
    logic       slave_miso;

    spi_master_flex_if #(.MAX_BITS(64), .DIV_W(16), .CS_W(1)) cmd_if ();

    spi_master_flex #(.MAX_BITS(64), .NUM_CS(2), .DIV_W(16)) dut (
        .i_sys_clk (clk),
        .i_reset_n (rst_n),
        .cmd       (cmd_if),
        .o_cs_n    (cs_n),
        .o_sck     (sck),
        .o_mosi    (mosi),
        .i_miso    (miso)
    );

    assign miso = loopback ? mosi : slave_miso;

    typedef struct {
        logic [63:0] rx;
        logic [63:0] mo;
        int          tog;
        int          cs_rise;
        int          done_rel;
        logic [1:0]  csm;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_err    = 0;
    int          cyc      = 0;
    int          t0       = 0;
    int          done_cnt = 0;
    int          tog_cnt  = 0;
    int          cs_fall_rel = 0;
    int          cs_rise_rel = 0;
    logic [1:0]  cs_seen  = '0;
    logic [63:0] mosi_cap = '0;
    logic [63:0] slave_tx = '0;
    int          cur_n    = 1;
    logic        cur_cpol = 1'b0;
    logic        cur_cpha = 1'b0;
    int          sl_bit   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] len_mask(input int n);
        logic [63:0] one = 64'd1;
        return (n >= 64) ? '1 : ((one << n) - 64'd1);
    endfunction

    // Bus-level slave: records MOSI on sampling edges, drives MISO on the other edges.
    initial begin
        logic cs_act, cs_act_p, sck_p, lead;
        int   rel;
        exp_t e;
        cs_act_p = 1'b0;
        sck_p    = 1'b0;
        forever begin
            @(negedge clk);
            rel    = cyc - t0 + 1;
            cs_act = ~&cs_n;
            if (cs_act && !cs_act_p) begin
                tog_cnt     = 0;
                mosi_cap    = '0;
                cs_seen     = ~cs_n;
                cs_fall_rel = rel;
                sl_bit      = cur_n - 1;
                if (!cur_cpha) begin
                    slave_miso = slave_tx[sl_bit];
                    sl_bit--;
                end
            end else if (cs_act) begin
                cs_seen |= ~cs_n;
                if (sck != sck_p) begin
                    tog_cnt++;
                    lead = (sck != cur_cpol);
                    if (lead ^ cur_cpha) begin
                        mosi_cap = {mosi_cap[62:0], mosi};
                    end else if (sl_bit >= 0) begin
                        slave_miso = slave_tx[sl_bit];
                        sl_bit--;
                    end
                end
            end
            if (!cs_act && cs_act_p) cs_rise_rel = rel;
            if (cmd_if.o_done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    check_val("spurious_done", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check_val("rx_data", cmd_if.o_rx_data, e.rx);
                    check_val("mosi_seq", mosi_cap, e.mo);
                    check_val("sck_toggles", 64'(tog_cnt), 64'(e.tog));
                    check_val("cs_fall_rel", 64'(cs_fall_rel), 64'd1);
                    check_val("cs_rise_rel", 64'(cs_rise_rel), 64'(e.cs_rise));
                    check_val("done_rel", 64'(rel), 64'(e.done_rel));
                    check_val("cs_lines", 64'(cs_seen), 64'(e.csm));
                    check_val("busy_at_done", 64'(cmd_if.o_busy), 64'd0);
                end
            end
            cs_act_p = cs_act;
            sck_p    = sck;
        end
    end

    task automatic start_xfer(input int n, input logic [63:0] tx, input logic cpol,
                              input logic cpha, input int div, input int cs,
                              input logic [63:0] sdata, input logic loop);
        exp_t e;
        int   d;
        d          = (div == 0) ? 1 : div;
        e.rx       = (loop ? tx : sdata) & len_mask(n);
        e.mo       = tx & len_mask(n);
        e.tog      = 2 * n;
        e.cs_rise  = 1 + (2 * n + 1) * d;
        e.done_rel = 1 + (2 * n + 2) * d;
        e.csm      = (cs < 2) ? 2'(1 << cs) : 2'b00;
        sb.push_back(e);
        @(negedge clk);
        cur_n    = n;
        cur_cpol = cpol;
        cur_cpha = cpha;
        slave_tx = sdata;
        loopback = loop;
        cmd_if.i_tx_data = tx;
        cmd_if.i_bit_len = 7'(n);
        cmd_if.i_cpol    = cpol;
        cmd_if.i_cpha    = cpha;
        cmd_if.i_div     = 16'(div);
        cmd_if.i_cs_sel  = 1'(cs);
        cmd_if.i_start   = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        cmd_if.i_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int start_cnt;
        int k;
        start_cnt = done_cnt;
        k = 0;
        while (done_cnt == start_cnt && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (done_cnt == start_cnt) check_val("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int base_cnt;
        int k;
        rst_n      = 1'b0;
        loopback   = 1'b1;
        slave_miso = 1'b0;
        cmd_if.i_start   = 1'b0;
        cmd_if.i_tx_data = '0;
        cmd_if.i_bit_len = '0;
        cmd_if.i_cs_sel  = '0;
        cmd_if.i_cpol    = 1'b0;
        cmd_if.i_cpha    = 1'b0;
        cmd_if.i_div     = '0;
        repeat (3) @(negedge clk);
        check_val("rst_busy", 64'(cmd_if.o_busy), 64'd0);
        check_val("rst_done", 64'(cmd_if.o_done), 64'd0);
        check_val("rst_rx", cmd_if.o_rx_data, 64'd0);
        check_val("rst_cs_n", 64'(cs_n), 64'h3);
        check_val("rst_sck", 64'(sck), 64'd0);
        check_val("rst_mosi", 64'(mosi), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Mode 0, N=8, D=2 loopback
        start_xfer(8, 64'hA5, 1'b0, 1'b0, 2, 0, 64'd0, 1'b1);
        @(negedge clk);
        #1;
        check_val("t1_busy", 64'(cmd_if.o_busy), 64'd1);
        check_val("t1_cs_n", 64'(cs_n), 64'h2);
        check_val("t1_sck", 64'(sck), 64'd0);
        check_val("t1_mosi_first", 64'(mosi), 64'd1);
        wait_done(200);
        @(negedge clk);
        #1;
        check_val("t1_done_pulse", 64'(cmd_if.o_done), 64'd0);
        check_val("t1_mosi_idle", 64'(mosi), 64'd0);

        // Mode 3, N=49, D=5 with slave data
        start_xfer(49, 64'h0001_5555_AAAA_3C3C, 1'b1, 1'b1, 5, 0, 64'h0001_2345_6789_ABCD, 1'b0);
        @(negedge clk);
        #1;
        check_val("t2_sck_setup", 64'(sck), 64'd1);
        wait_done(2000);
        @(negedge clk);
        #1;
        check_val("t2_sck_idle", 64'(sck), 64'd1);

        // Divider 0 behaves as 1, N=1, mode 1
        start_xfer(1, 64'd1, 1'b0, 1'b1, 0, 0, 64'd0, 1'b1);
        wait_done(100);

        // cs_sel=1, N=64 with ignored mid-transfer starts
        base_cnt = done_cnt;
        start_xfer(64, 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b0, 1, 1, 64'd0, 1'b1);
        for (int p = 0; p < 3; p++) begin
            repeat (20) @(negedge clk);
            cmd_if.i_bit_len = 7'd5;
            cmd_if.i_start   = 1'b1;
            @(negedge clk);
            cmd_if.i_start   = 1'b0;
        end
        wait_done(1000);
        repeat (20) @(negedge clk);
        #1;
        check_val("t4_one_done", 64'(done_cnt - base_cnt), 64'd1);

        // Invalid lengths 0 and 65 are ignored
        base_cnt = done_cnt;
        for (int p = 0; p < 2; p++) begin
            @(negedge clk);
            cmd_if.i_bit_len = (p == 0) ? 7'd0 : 7'd65;
            cmd_if.i_start   = 1'b1;
            @(negedge clk);
            cmd_if.i_start   = 1'b0;
            #1;
            check_val("t5_no_busy", 64'(cmd_if.o_busy), 64'd0);
            check_val("t5_cs_high", 64'(cs_n), 64'h3);
        end
        repeat (10) @(negedge clk);
        #1;
        check_val("t5_no_done", 64'(done_cnt - base_cnt), 64'd0);
        check_val("t5_rx_hold", cmd_if.o_rx_data, 64'hDEAD_BEEF_0123_4567);
        start_xfer(4, 64'hC, 1'b1, 1'b0, 3, 0, 64'd0, 1'b1);
        wait_done(200);

        // Reset during an N=16 transfer after the 7th SCK edge
        start_xfer(16, 64'h1234, 1'b0, 1'b0, 2, 0, 64'd0, 1'b1);
        @(negedge clk);
        #1;
        k = 0;
        while (tog_cnt < 7 && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        check_val("t6_reached_edge7", 64'(tog_cnt), 64'd7);
        base_cnt = done_cnt;
        rst_n = 1'b0;
        #1;
        check_val("t6_cs_n", 64'(cs_n), 64'h3);
        check_val("t6_sck", 64'(sck), 64'd0);
        check_val("t6_busy", 64'(cmd_if.o_busy), 64'd0);
        check_val("t6_rx", cmd_if.o_rx_data, 64'd0);
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (80) @(negedge clk);
        #1;
        check_val("t6_no_done", 64'(done_cnt - base_cnt), 64'd0);
        start_xfer(16, 64'hBEEF, 1'b0, 1'b0, 2, 0, 64'd0, 1'b1);
        wait_done(300);
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
